// File: rtl/semaforo_monitor.sv
// rtl/semaforo_monitor.sv - independent lamp-sequence checker for the two-way traffic-light controller
//
// Purpose: decodes the four lamp drives of the controller into per-light
// states, checks transition order, right-of-way conflicts and amber/green
// durations, and keeps a sticky first-fault code plus a saturating fault count.
//
// Ports:
//   CLK100MHZ    in   system clock
//   RST          in   asynchronous active-high reset
//   CLR          in   synchronous single-cycle fault clear
//   R16, G16     in   light 1 red/green lamp drives (asynchronous to CLK100MHZ)
//   R17, G17     in   light 2 red/green lamp drives (asynchronous to CLK100MHZ)
//   FAULT        out  sticky fault flag
//   FAULT_CODE   out  code of the first fault since the last clear
//   FAULT_COUNT  out  number of cycles containing a fault event, saturating at 255
//   L1_STATE     out  decoded light 1 state (0 dark, 1 red, 2 green, 3 amber)
//   L2_STATE     out  decoded light 2 state
module semaforo_monitor #(
  parameter int unsigned TICKS_PER_SEC = 100000000,
  parameter int unsigned MIN_AMBER_S   = 5,
  parameter int unsigned MAX_GREEN_S   = 10
) (
  input  logic       CLK100MHZ,
  input  logic       RST,
  input  logic       CLR,
  input  logic       R16,
  input  logic       G16,
  input  logic       R17,
  input  logic       G17,
  output logic       FAULT,
  output logic [2:0] FAULT_CODE,
  output logic [7:0] FAULT_COUNT,
  output logic [1:0] L1_STATE,
  output logic [1:0] L2_STATE
);

  localparam int unsigned   CW        = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(TICKS_PER_SEC - 1);
  localparam logic [5:0]    MAX_GREEN = 6'(MAX_GREEN_S);
  localparam logic [6:0]    MIN_AMBER = 7'(MIN_AMBER_S);

  // Encoding equals {G,R} of the lamp pair, so decoding is a plain bit swap.
  typedef enum logic [1:0] {
    DARK  = 2'd0,
    RED   = 2'd1,
    GREEN = 2'd2,
    AMBER = 2'd3
  } lamp_e;

  // Synchronizer bit order: {R16, G16, R17, G17}
  logic [3:0]    sync1_q, sync2_q;

  lamp_e         state_q [2];
  lamp_e         cur     [2];
  logic [CW-1:0] cnt_q   [2];
  logic [CW-1:0] cnt_d   [2];
  logic [5:0]    sec_q   [2];
  logic [5:0]    sec_d   [2];
  logic [6:0]    sec_exit[2];

  logic [1:0]    trans, wrap, illegal, short_amber, long_green;
  logic          conflict_now, conflict_q;
  logic [5:1]    ev;
  logic          any_ev;
  logic [2:0]    code_sel;

  logic          fault_q, fault_d;
  logic [2:0]    code_q, code_d;
  logic [7:0]    count_q, count_d;

  assign cur[0] = lamp_e'({sync2_q[2], sync2_q[3]});
  assign cur[1] = lamp_e'({sync2_q[0], sync2_q[1]});

  // Per-light transition detection, legality and phase timing
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      trans[i]    = (cur[i] != state_q[i]);
      wrap[i]     = (cnt_q[i] == CNT_MAX);
      // Seconds including the cycle being evaluated, so a phase held for
      // exactly k seconds reads k when it ends.
      sec_exit[i] = {1'b0, sec_q[i]} + {6'd0, wrap[i]};
      illegal[i]  = trans[i] &&
                    ((state_q[i] == GREEN && cur[i] == RED)   ||
                     (state_q[i] == RED   && cur[i] == AMBER) ||
                     (state_q[i] == AMBER && cur[i] == GREEN));
      short_amber[i] = trans[i] && state_q[i] == AMBER && cur[i] == RED &&
                       sec_exit[i] < MIN_AMBER;
      // Seconds only pass MAX_GREEN once per phase, so this fires once.
      long_green[i]  = !trans[i] && cur[i] == GREEN && wrap[i] && sec_q[i] == MAX_GREEN;

      cnt_d[i] = cnt_q[i];
      sec_d[i] = sec_q[i];
      if (trans[i]) begin
        cnt_d[i] = '0;
        sec_d[i] = '0;
      end else if (wrap[i]) begin
        cnt_d[i] = '0;
        if (sec_q[i] != 6'd63) sec_d[i] = sec_q[i] + 6'd1;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Event collection and fault bookkeeping
  always_comb begin
    conflict_now = (cur[0] inside {GREEN, AMBER}) && (cur[1] inside {GREEN, AMBER});
    ev[1]  = conflict_now && !conflict_q;
    ev[2]  = illegal[0];
    ev[3]  = illegal[1];
    ev[4]  = |short_amber;
    ev[5]  = |long_green;
    any_ev = |ev;

    code_sel = 3'd0;
    for (int k = 5; k >= 1; k--) begin
      if (ev[k]) code_sel = 3'(k);
    end

    fault_d = fault_q;
    code_d  = code_q;
    count_d = count_q;
    if (CLR) begin
      // A same-cycle event survives the clear as the first fault.
      fault_d = any_ev;
      code_d  = code_sel;
      count_d = any_ev ? 8'd1 : 8'd0;
    end else if (any_ev) begin
      fault_d = 1'b1;
      if (!fault_q) code_d = code_sel;
      if (count_q != 8'hFF) count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      conflict_q <= 1'b0;
      fault_q    <= 1'b0;
      code_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= DARK;
        cnt_q[i]   <= '0;
        sec_q[i]   <= '0;
      end
    end else begin
      sync1_q    <= {R16, G16, R17, G17};
      sync2_q    <= sync1_q;
      conflict_q <= conflict_now;
      fault_q    <= fault_d;
      code_q     <= code_d;
      count_q    <= count_d;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= cur[i];
        cnt_q[i]   <= cnt_d[i];
        sec_q[i]   <= sec_d[i];
      end
    end
  end

  assign FAULT       = fault_q;
  assign FAULT_CODE  = code_q;
  assign FAULT_COUNT = count_q;
  assign L1_STATE    = state_q[0];
  assign L2_STATE    = state_q[1];

endmodule

// File: tb/tb_semaforo_monitor.sv
// tb/tb_semaforo_monitor.sv - directed and random checks of semaforo_monitor against a phase-length model
module tb_semaforo_monitor;

  localparam int T    = 4;
  localparam int MINA = 2;
  localparam int MAXG = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       r16 = 1'b0, g16 = 1'b0, r17 = 1'b0, g17 = 1'b0;
  logic       fault;
  logic [2:0] fault_code;
  logic [7:0] fault_count;
  logic [1:0] l1_state, l2_state;

  int errors = 0;
  int checks = 0;

  semaforo_monitor #(
    .TICKS_PER_SEC(T),
    .MIN_AMBER_S  (MINA),
    .MAX_GREEN_S  (MAXG)
  ) dut (
    .CLK100MHZ  (clk),
    .RST        (rst),
    .CLR        (clr),
    .R16        (r16),
    .G16        (g16),
    .R17        (r17),
    .G17        (g17),
    .FAULT      (fault),
    .FAULT_CODE (fault_code),
    .FAULT_COUNT(fault_count),
    .L1_STATE   (l1_state),
    .L2_STATE   (l2_state)
  );

  always #5 clk = ~clk;

  // Reference model: lamp history delayed two cycles, per-light phase length
  // in cycles, seconds derived by division at the point of use.
  logic [3:0] m_s1, m_s2;
  int         m_prev[2];
  int         m_len[2];
  bit         m_conf;
  bit         m_fault;
  int         m_code;
  int         m_count;

  function automatic int decode(logic r, logic g);
    if (!r && !g) return 0;
    if (r && !g)  return 1;
    if (!r && g)  return 2;
    return 3;
  endfunction

  // Red -> green -> amber -> red cycle; dark is free in both directions.
  function automatic bit legal(int p, int c);
    return (p == c) || (p == 0) || (c == 0) || (c == (p % 3) + 1);
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0;
    m_prev[0] = 0; m_prev[1] = 0;
    m_len[0] = 0; m_len[1] = 0;
    m_conf = 1'b0; m_fault = 1'b0; m_code = 0; m_count = 0;
  endtask

  task automatic model_edge();
    int  cur[2];
    bit  ev[6];
    bit  conf, any;
    int  pick, secs;
    if (rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 6; k++) ev[k] = 1'b0;
    cur[0] = decode(m_s2[3], m_s2[2]);
    cur[1] = decode(m_s2[1], m_s2[0]);
    for (int i = 0; i < 2; i++) begin
      if (cur[i] != m_prev[i]) begin
        if (!legal(m_prev[i], cur[i])) ev[2 + i] = 1'b1;
        secs = m_len[i] / T;
        if (secs > 63) secs = 63;
        if (m_prev[i] == 3 && cur[i] == 1 && secs < MINA) ev[4] = 1'b1;
        m_len[i] = 1;
      end else begin
        if (cur[i] == 2 && m_len[i] == (MAXG + 1) * T) ev[5] = 1'b1;
        if (m_len[i] < 1000000) m_len[i]++;
      end
      m_prev[i] = cur[i];
    end
    conf = (cur[0] >= 2) && (cur[1] >= 2);
    if (conf && !m_conf) ev[1] = 1'b1;
    m_conf = conf;
    any  = 1'b0;
    pick = 0;
    for (int k = 5; k >= 1; k--) if (ev[k]) begin any = 1'b1; pick = k; end
    if (clr) begin
      m_fault = any;
      m_code  = pick;
      m_count = any ? 1 : 0;
    end else if (any) begin
      if (!m_fault) m_code = pick;
      m_fault = 1'b1;
      if (m_count < 255) m_count++;
    end
    m_s2 = m_s1;
    m_s1 = {r16, g16, r17, g17};
  endtask

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("fault",       {7'd0, fault},  {7'd0, m_fault});
    chk("fault_code",  {5'd0, fault_code}, 8'(m_code));
    chk("fault_count", fault_count,    8'(m_count));
    chk("l1_state",    {6'd0, l1_state}, 8'(m_prev[0]));
    chk("l2_state",    {6'd0, l2_state}, 8'(m_prev[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  task automatic set_lights(int l1, int l2);
    r16 = (l1 == 1 || l1 == 3);
    g16 = (l1 == 2 || l1 == 3);
    r17 = (l2 == 1 || l2 == 3);
    g17 = (l2 == 2 || l2 == 3);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int l1, l2;
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    tick();
    tick();
    rst = 1'b0;

    // Legal cycle on light 1, light 2 red
    set_lights(1, 1); run(8);
    set_lights(2, 1); run(8);
    set_lights(3, 1); run(8);
    set_lights(1, 1); run(8);

    // Conflict, then light 2 green -> red
    set_lights(2, 2); run(12);
    set_lights(2, 1); run(6);
    set_lights(1, 1); run(4);
    pulse_clr(); run(2);

    // Short amber, then adequate amber
    set_lights(2, 1); run(4);
    set_lights(3, 1); run(4);
    set_lights(1, 1); run(6);
    pulse_clr();
    set_lights(2, 1); run(4);
    set_lights(3, 1); run(8);
    set_lights(1, 1); run(6);

    // Long green held well past the limit
    set_lights(2, 1); run(40);
    set_lights(3, 1); run(8);
    set_lights(1, 1); run(4);
    pulse_clr(); run(2);

    // Five illegal light-1 transitions, then CLR on the light-2 red->amber edge
    repeat (5) begin
      set_lights(2, 1); run(2);
      set_lights(1, 1); run(2);
    end
    set_lights(1, 3); run(2);
    pulse_clr(); run(4);
    set_lights(1, 1); run(4);

    // Reset during amber with a fault latched
    set_lights(2, 1); run(3);
    set_lights(1, 1); run(3);
    set_lights(3, 1); run(3);
    async_reset();
    set_lights(1, 1); run(10);

    // Random lamp sequences with occasional clears and resets
    l1 = 1; l2 = 1;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(5) == 0) l1 = int'($urandom_range(3));
      if ($urandom_range(5) == 0) l2 = int'($urandom_range(3));
      set_lights(l1, l2);
      clr = ($urandom_range(39) == 0);
      if ($urandom_range(249) == 0) async_reset();
      else tick();
    end
    clr = 1'b0;
    set_lights(1, 1); run(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
